// File: rtl/regalu_pkg.sv
// Shared definitions for the RegFile/ALU interface and its result checker.
package regalu_pkg;

    // Checker FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StCmp  = 2'd2,
        StDone = 2'd3
    } state_e;

    // Default datapath width.
    localparam int unsigned DefaultDataW = 16;

    // ALU flag bit positions.
    localparam int unsigned FlagC = 0;

endpackage

// File: rtl/fib_model.sv
// Fibonacci reference model: holds (a, b), exposes b as the expected value
// and the carry that the next advance would produce.
module fib_model
    import regalu_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              advance_i,
    output logic [DATA_W-1:0] exp_o,
    output logic              carry_o
);

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W:0]   sum;

    // Next-term computation; the sum wraps to DATA_W bits, its top bit is the carry.
    always_comb begin
        sum = {1'b0, a_q} + {1'b0, b_q};
        a_d = a_q;
        b_d = b_q;
        if (advance_i) begin
            a_d = b_q;
            b_d = sum[DATA_W-1:0];
        end
    end

    // Model registers with synchronous active-low reset to (0, 1).
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_q <= '0;
            b_q <= DATA_W'(1);
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign exp_o   = b_q;
    assign carry_o = sum[DATA_W];

endmodule

// File: rtl/fib_result_checker.sv
// Snoops sequencer write commands, samples RdestOut after the datapath latency
// and checks it against a Fibonacci model. Never drives the datapath.
module fib_result_checker
    import regalu_pkg::*;
#(
    parameter int unsigned DATA_W     = DefaultDataW,
    parameter int unsigned RESULT_LAT = 1,
    parameter int unsigned MAX_WRITES = 24,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              En,
    input  logic [3:0]        RdestRegLoc,
    input  logic [DATA_W-1:0] RdestOut,
    input  logic [4:0]        Flags,
    output logic              Busy,
    output logic              Done,
    output logic              Pass,
    output logic              Fail,
    output logic              Ovf,
    output logic [CNT_W-1:0]  WriteCount,
    output logic [CNT_W-1:0]  ErrCount,
    output logic [DATA_W-1:0] ExpOut,
    output logic [3:0]        LastReg
);

    localparam logic [1:0]       LatInit   = 2'(RESULT_LAT);
    localparam bit               LatDirect = (RESULT_LAT <= 1);
    localparam logic [CNT_W-1:0] LastCount = CNT_W'(MAX_WRITES - 1);

    state_e            state_q, state_d;
    logic [1:0]        lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0]  write_cnt_q, write_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              ovf_q, ovf_d;
    logic [3:0]        last_reg_q, last_reg_d;

    logic [DATA_W-1:0] exp_val;
    logic              model_carry;
    logic              in_cmp;
    logic              last_cmp;
    logic              ovf_hit;
    logic              finish;
    logic              mismatch;
    logic              proto_err;
    logic              accept;
    logic              err_inc;

    // Flags are observed for debug only; the model's own carry drives Ovf.
    logic unused_flags;
    assign unused_flags = ^Flags;

    fib_model #(
        .DATA_W (DATA_W)
    ) u_fib_model (
        .clk_i     (Clk),
        .rst_ni    (Rst),
        .advance_i (in_cmp),
        .exp_o     (exp_val),
        .carry_o   (model_carry)
    );

    // Compare-cycle decode. A carry on the final compare is ignored: no
    // further term will ever be checked, so it is not an overflow.
    always_comb begin
        in_cmp    = (state_q == StCmp);
        last_cmp  = in_cmp && (write_cnt_q == LastCount);
        ovf_hit   = in_cmp && model_carry && !last_cmp;
        finish    = last_cmp || ovf_hit;
        mismatch  = in_cmp && (RdestOut != exp_val);
        proto_err = En && (state_q == StWait);
        accept    = En && ((state_q == StIdle) || (in_cmp && !finish));
        err_inc   = mismatch || proto_err;
    end

    // State and status registers, synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q     <= StIdle;
            lat_cnt_q   <= '0;
            write_cnt_q <= '0;
            err_cnt_q   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            ovf_q       <= 1'b0;
            last_reg_q  <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            write_cnt_q <= write_cnt_d;
            err_cnt_q   <= err_cnt_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            ovf_q       <= ovf_d;
            last_reg_q  <= last_reg_d;
        end
    end

    // Next-state logic; latency 1 goes straight from the command to CMP.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (En) begin
                    lat_cnt_d = LatInit;
                    state_d   = LatDirect ? StCmp : StWait;
                end
            end
            StWait: begin
                lat_cnt_d = lat_cnt_q - 2'd1;
                if (lat_cnt_q <= 2'd2) begin
                    state_d = StCmp;
                end
            end
            StCmp: begin
                if (finish) begin
                    state_d = StDone;
                end else if (En) begin
                    lat_cnt_d = LatInit;
                    state_d   = LatDirect ? StCmp : StWait;
                end else begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Counters and sticky status; ErrCount saturates instead of wrapping.
    always_comb begin
        write_cnt_d = in_cmp ? write_cnt_q + CNT_W'(1) : write_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (err_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        fail_d     = fail_q || err_inc;
        ovf_d      = ovf_q || ovf_hit;
        done_d     = done_q || finish;
        pass_d     = done_d && (err_cnt_d == '0) && !ovf_d;
        last_reg_d = accept ? RdestRegLoc : last_reg_q;
    end

    // Outputs.
    always_comb begin
        Busy       = (state_q == StWait) || (state_q == StCmp);
        Done       = done_q;
        Pass       = pass_q;
        Fail       = fail_q;
        Ovf        = ovf_q;
        WriteCount = write_cnt_q;
        ErrCount   = err_cnt_q;
        ExpOut     = exp_val;
        LastReg    = last_reg_q;
    end

endmodule

// File: tb/tb_fib_result_checker.sv
// Bench for fib_result_checker: dut0 (latency 1, 24 writes) and dut1
// (latency 3, 30 writes), each fed by a small datapath delay line and
// checked every cycle against an event-level model.
module tb_fib_result_checker;

    logic        clk = 1'b0;
    logic        rst_s  [2];
    logic        en_s   [2];
    logic [3:0]  reg_s  [2];
    logic [15:0] wd_s   [2];
    logic [15:0] rout   [2];
    logic [4:0]  flags = 5'h0;

    logic        busy_o [2];
    logic        done_o [2];
    logic        pass_o [2];
    logic        fail_o [2];
    logic        ovf_o  [2];
    logic [7:0]  wcnt_o [2];
    logic [7:0]  ecnt_o [2];
    logic [15:0] exp_o  [2];
    logic [3:0]  last_o [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fib_result_checker #(
        .DATA_W     (16),
        .RESULT_LAT (1),
        .MAX_WRITES (24),
        .CNT_W      (8)
    ) u_dut0 (
        .Clk         (clk),
        .Rst         (rst_s[0]),
        .En          (en_s[0]),
        .RdestRegLoc (reg_s[0]),
        .RdestOut    (rout[0]),
        .Flags       (flags),
        .Busy        (busy_o[0]),
        .Done        (done_o[0]),
        .Pass        (pass_o[0]),
        .Fail        (fail_o[0]),
        .Ovf         (ovf_o[0]),
        .WriteCount  (wcnt_o[0]),
        .ErrCount    (ecnt_o[0]),
        .ExpOut      (exp_o[0]),
        .LastReg     (last_o[0])
    );

    fib_result_checker #(
        .DATA_W     (16),
        .RESULT_LAT (3),
        .MAX_WRITES (30),
        .CNT_W      (8)
    ) u_dut1 (
        .Clk         (clk),
        .Rst         (rst_s[1]),
        .En          (en_s[1]),
        .RdestRegLoc (reg_s[1]),
        .RdestOut    (rout[1]),
        .Flags       (flags),
        .Busy        (busy_o[1]),
        .Done        (done_o[1]),
        .Pass        (pass_o[1]),
        .Fail        (fail_o[1]),
        .Ovf         (ovf_o[1]),
        .WriteCount  (wcnt_o[1]),
        .ErrCount    (ecnt_o[1]),
        .ExpOut      (exp_o[1]),
        .LastReg     (last_o[1])
    );

    // Datapath emulation: a written value appears on RdestOut RESULT_LAT cycles later.
    logic [15:0] pipe0 = 16'h0;
    logic [15:0] pipe1 [3] = '{16'h0, 16'h0, 16'h0};
    always @(posedge clk) begin
        pipe0    <= en_s[0] ? wd_s[0] : 16'h0;
        pipe1[0] <= en_s[1] ? wd_s[1] : 16'h0;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign rout[0] = pipe0;
    assign rout[1] = pipe1[2];

    function automatic longint fib(input int n);
        longint a = 0;
        longint b = 1;
        longint t;
        if (n == 0) return 0;
        for (int k = 1; k < n; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int max_of(input int i);
        return (i == 0) ? 24 : 30;
    endfunction

    task automatic check(input string nm, input int i, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d @%0t: got %0d, want %0d", nm, i, $time, act, exp);
        end
    endtask

    // Event-level model: a pending write is due a fixed number of cycles after
    // its command; the compare index selects F(n) directly.
    bit         m_pend [2];
    int         m_due  [2];
    int         m_cnt  [2];
    int         m_errc [2];
    bit         m_fail [2];
    bit         m_ovf  [2];
    bit         m_done [2];
    logic [3:0] m_last [2];
    int         cyc = 0;
    bit         started = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_s[i]) begin
                m_pend[i] = 0; m_cnt[i] = 0; m_errc[i] = 0; m_fail[i] = 0;
                m_ovf[i] = 0; m_done[i] = 0; m_last[i] = 4'h0;
            end else if (!m_done[i]) begin
                if (m_pend[i] && cyc == m_due[i]) begin
                    m_cnt[i]++;
                    if (rout[i] !== 16'(fib(m_cnt[i]))) begin
                        m_errc[i] = (m_errc[i] < 255) ? m_errc[i] + 1 : m_errc[i];
                        m_fail[i] = 1;
                    end
                    if (m_cnt[i] == max_of(i)) begin
                        m_done[i] = 1;
                    end else if (fib(m_cnt[i] + 1) > 65535) begin
                        m_ovf[i]  = 1;
                        m_done[i] = 1;
                    end
                    m_pend[i] = 0;
                    if (!m_done[i] && en_s[i]) begin
                        m_pend[i] = 1; m_due[i] = cyc + lat_of(i); m_last[i] = reg_s[i];
                    end
                end else if (m_pend[i]) begin
                    if (en_s[i]) begin
                        m_errc[i] = (m_errc[i] < 255) ? m_errc[i] + 1 : m_errc[i];
                        m_fail[i] = 1;
                    end
                end else if (en_s[i]) begin
                    m_pend[i] = 1; m_due[i] = cyc + lat_of(i); m_last[i] = reg_s[i];
                end
            end
        end
        cyc++;
        started = 1'b1;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                check("Busy", i, 32'(busy_o[i]), 32'(m_pend[i]));
                check("Done", i, 32'(done_o[i]), 32'(m_done[i]));
                check("Pass", i, 32'(pass_o[i]),
                      32'(m_done[i] && m_errc[i] == 0 && !m_ovf[i]));
                check("Fail", i, 32'(fail_o[i]), 32'(m_fail[i]));
                check("Ovf", i, 32'(ovf_o[i]), 32'(m_ovf[i]));
                check("WriteCount", i, 32'(wcnt_o[i]), 32'(m_cnt[i]));
                check("ErrCount", i, 32'(ecnt_o[i]), 32'(m_errc[i]));
                check("ExpOut", i, 32'(exp_o[i]), 32'(fib(m_cnt[i] + 1) & 64'hFFFF));
                check("LastReg", i, 32'(last_o[i]), 32'(m_last[i]));
            end
        end
    end

    task automatic step(input int i, input logic e, input logic [3:0] r,
                        input logic [15:0] d);
        en_s[i]  = e;
        reg_s[i] = r;
        wd_s[i]  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int i);
        rst_s[i] = 1'b0;
        step(i, 1'b0, 4'h0, 16'h0);
        rst_s[i] = 1'b1;
    endtask

    // One command followed by idle cycles until the compare has happened.
    task automatic do_write(input int i, input logic [3:0] r, input logic [15:0] d);
        step(i, 1'b1, r, d);
        repeat (lat_of(i)) step(i, 1'b0, 4'h0, 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b0; en_s[i] = 1'b0; reg_s[i] = 4'h0; wd_s[i] = 16'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("lit_reset_exp", 0, 32'(exp_o[0]), 32'd1);
        check("lit_reset_busy", 1, 32'(busy_o[1]), 32'd0);

        // Correct stream on dut0.
        do_reset(0);
        for (int n = 1; n <= 24; n++) do_write(0, 4'(n), 16'(fib(n)));
        check("lit_t1_wcnt", 0, 32'(wcnt_o[0]), 32'd24);
        check("lit_t1_ecnt", 0, 32'(ecnt_o[0]), 32'd0);
        check("lit_t1_done", 0, 32'(done_o[0]), 32'd1);
        check("lit_t1_pass", 0, 32'(pass_o[0]), 32'd1);
        check("lit_t1_ovf", 0, 32'(ovf_o[0]), 32'd0);
        check("lit_t1_exp", 0, 32'(exp_o[0]), 32'd9489);
        repeat (2) step(0, 1'b1, 4'h9, 16'h1234);
        check("lit_t1_absorb", 0, 32'(wcnt_o[0]), 32'd24);
        step(0, 1'b0, 4'h0, 16'h0);

        // Fifth result corrupted (6 instead of 5).
        do_reset(0);
        for (int n = 1; n <= 24; n++) begin
            do_write(0, 4'(n), (n == 5) ? 16'd6 : 16'(fib(n)));
            if (n == 5) begin
                check("lit_t2_ecnt5", 0, 32'(ecnt_o[0]), 32'd1);
                check("lit_t2_fail5", 0, 32'(fail_o[0]), 32'd1);
                check("lit_t2_exp5", 0, 32'(exp_o[0]), 32'd8);
            end
        end
        check("lit_t2_done", 0, 32'(done_o[0]), 32'd1);
        check("lit_t2_pass", 0, 32'(pass_o[0]), 32'd0);

        // Back-to-back commands at latency 1.
        do_reset(0);
        step(0, 1'b1, 4'h1, 16'd1);
        check("lit_b2b_busy1", 0, 32'(busy_o[0]), 32'd1);
        step(0, 1'b1, 4'h2, 16'd1);
        check("lit_b2b_busy2", 0, 32'(busy_o[0]), 32'd1);
        step(0, 1'b1, 4'h3, 16'd2);
        check("lit_b2b_busy3", 0, 32'(busy_o[0]), 32'd1);
        step(0, 1'b1, 4'h4, 16'd3);
        check("lit_b2b_busy4", 0, 32'(busy_o[0]), 32'd1);
        step(0, 1'b0, 4'h0, 16'h0);
        check("lit_b2b_wcnt", 0, 32'(wcnt_o[0]), 32'd4);
        check("lit_b2b_ecnt", 0, 32'(ecnt_o[0]), 32'd0);
        check("lit_b2b_last", 0, 32'(last_o[0]), 32'd4);

        // Protocol overlap at latency 3.
        do_reset(1);
        step(1, 1'b1, 4'h3, 16'd1);
        step(1, 1'b1, 4'h7, 16'd99);
        repeat (3) step(1, 1'b0, 4'h0, 16'h0);
        check("lit_ovl_ecnt", 1, 32'(ecnt_o[1]), 32'd1);
        check("lit_ovl_fail", 1, 32'(fail_o[1]), 32'd1);
        check("lit_ovl_wcnt", 1, 32'(wcnt_o[1]), 32'd1);
        check("lit_ovl_last", 1, 32'(last_o[1]), 32'd3);

        // Overflow with MAX_WRITES=30.
        do_reset(1);
        for (int n = 1; n <= 26; n++) do_write(1, 4'(n), 16'(fib(n)));
        check("lit_ovf_ovf", 1, 32'(ovf_o[1]), 32'd1);
        check("lit_ovf_done", 1, 32'(done_o[1]), 32'd1);
        check("lit_ovf_pass", 1, 32'(pass_o[1]), 32'd0);
        check("lit_ovf_wcnt", 1, 32'(wcnt_o[1]), 32'd24);
        check("lit_ovf_ecnt", 1, 32'(ecnt_o[1]), 32'd0);

        // Reset while in WAIT after 10 writes.
        do_reset(1);
        for (int n = 1; n <= 10; n++) do_write(1, 4'(n), 16'(fib(n)));
        step(1, 1'b1, 4'hB, 16'(fib(11)));
        check("lit_rst_inwait", 1, 32'(busy_o[1]), 32'd1);
        do_reset(1);
        check("lit_rst_exp", 1, 32'(exp_o[1]), 32'd1);
        check("lit_rst_wcnt", 1, 32'(wcnt_o[1]), 32'd0);
        check("lit_rst_busy", 1, 32'(busy_o[1]), 32'd0);
        check("lit_rst_last", 1, 32'(last_o[1]), 32'd0);
        do_write(1, 4'h5, 16'd1);
        check("lit_rst_restart_wcnt", 1, 32'(wcnt_o[1]), 32'd1);
        check("lit_rst_restart_ecnt", 1, 32'(ecnt_o[1]), 32'd0);
        check("lit_rst_restart_exp", 1, 32'(exp_o[1]), 32'd1);
        repeat (2) step(1, 1'b0, 4'h0, 16'h0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
